// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the write-port arbiter's pipeline, MDU, scoreboard and register-file signals.
// master = pipeline/MDU/register-file side, slave = arbiter.
interface regfile_write_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;

  logic        pend_set;
  logic [4:0]  pend_reg;
  logic [4:0]  rs_reg;
  logic [4:0]  rt_reg;
  logic        stall;

  logic        hold_req;

  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  modport master (
    output wb_valid, wb_reg, wb_data,
    output mdu_valid, mdu_reg, mdu_data,
    input  mdu_ready,
    output pend_set, pend_reg, rs_reg, rt_reg,
    input  stall, hold_req,
    input  RegWrite, WriteRegister, WriteData
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  mdu_valid, mdu_reg, mdu_data,
    output mdu_ready,
    input  pend_set, pend_reg, rs_reg, rt_reg,
    output stall, hold_req,
    output RegWrite, WriteRegister, WriteData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and a one-entry MDU buffer.
// Optional RAW-hazard scoreboard built when REGFILE_ARB_SCOREBOARD_EN is defined.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | buffer free, mdu_ready=1
// FULL  | buffer holds an MDU result waiting for an idle write slot
// HOLD  | buffer full and starved; hold_req=1 asks the pipeline to idle
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    HOLD  = 2'd2
  } bufState_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  bufState_t        state, stateNext;
  logic [CNT_W-1:0] starveCnt, starveCntNext;
  logic [4:0]       bufReg;
  logic [31:0]      bufData;

  logic wbWin;
  logic bufOccupied;
  logic drain;
  logic handshake;
  logic bufLoad;

  assign wbWin       = bus.wb_valid && (bus.wb_reg != 5'd0);
  assign bufOccupied = (state != EMPTY);
  assign drain       = bufOccupied && !wbWin;

  // Ready is gated by reset so the MDU never sees a handshake while the buffer is held in reset.
  assign bus.mdu_ready = (state == EMPTY) && reset;
  assign handshake     = bus.mdu_valid && bus.mdu_ready;
  assign bufLoad       = handshake && (bus.mdu_reg != 5'd0);
  assign bus.hold_req  = (state == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveCntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    starveCntNext = starveCnt;
    case (state)
      EMPTY: begin
        starveCntNext = '0;
        if (bufLoad) stateNext = FULL;
      end
      FULL: begin
        if (drain) begin
          stateNext     = EMPTY;
          starveCntNext = '0;
        end else begin
          if (starveCnt != CNT_MAX) starveCntNext = starveCnt + CNT_W'(1);
          // This loss brings the count to the limit, so hold starts next cycle.
          if (starveCnt >= LIMIT_M1) stateNext = HOLD;
        end
      end
      HOLD: begin
        if (drain) begin
          stateNext     = EMPTY;
          starveCntNext = '0;
        end else if (starveCnt != CNT_MAX) begin
          starveCntNext = starveCnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext     = EMPTY;
        starveCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bufReg  <= 5'd0;
      bufData <= 32'd0;
    end else if (bufLoad) begin
      bufReg  <= bus.mdu_reg;
      bufData <= bus.mdu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.RegWrite      <= 1'b0;
      bus.WriteRegister <= 5'd0;
      bus.WriteData     <= 32'd0;
    end else begin
      bus.RegWrite <= wbWin || drain;
      if (wbWin) begin
        bus.WriteRegister <= bus.wb_reg;
        bus.WriteData     <= bus.wb_data;
      end else if (drain) begin
        bus.WriteRegister <= bufReg;
        bus.WriteData     <= bufData;
      end
    end
  end

`ifdef REGFILE_ARB_SCOREBOARD_EN
  logic [31:0] pending, pendingNext;

  // Clear first so a same-cycle set of the draining register wins; bit 0 is never pending.
  always_comb begin
    pendingNext = pending;
    if (drain) pendingNext[bufReg] = 1'b0;
    if (bus.pend_set && (bus.pend_reg != 5'd0)) pendingNext[bus.pend_reg] = 1'b1;
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pendingNext;
  end

  assign bus.stall = pending[bus.rs_reg] | pending[bus.rt_reg];
`else
  logic unusedScoreboardInputs;
  assign unusedScoreboardInputs = ^{bus.pend_set, bus.pend_reg, bus.rs_reg, bus.rt_reg};
  assign bus.stall = 1'b0;
`endif

  hold_needs_data: assert property (@(posedge clk) disable iff (!reset)
    (state == HOLD) |-> bufOccupied);
  no_handshake_when_full: assert property (@(posedge clk) disable iff (!reset)
    bufOccupied |-> !handshake);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a loss-counting reference model.
module tb_regfile_write_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if ifc();

  regfile_write_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: an occupied flag plus a count of consecutive lost slots.
  bit        mBufValid;
  bit [4:0]  mBufReg;
  bit [31:0] mBufData;
  int        mLosses;
  bit [31:0] mPending;

  function automatic bit modelStall(input bit [4:0] rs, input bit [4:0] rt);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    return mPending[rs] | mPending[rt];
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit modelHold();
    return mBufValid && (mLosses >= STARVE_LIMIT);
  endfunction

  task automatic modelClear();
    mBufValid = 1'b0;
    mBufReg   = 5'd0;
    mBufData  = 32'd0;
    mLosses   = 0;
    mPending  = 32'd0;
  endtask

  task automatic step(input bit wbV, input bit [4:0] wbR, input bit [31:0] wbD,
                      input bit mduV, input bit [4:0] mduR, input bit [31:0] mduD,
                      input bit pSet, input bit [4:0] pReg,
                      input bit [4:0] rs, input bit [4:0] rt);
    bit        wbWin, drain, hs, expWrite;
    bit [4:0]  expReg;
    bit [31:0] expData;
    ifc.wb_valid  = wbV;  ifc.wb_reg  = wbR;  ifc.wb_data  = wbD;
    ifc.mdu_valid = mduV; ifc.mdu_reg = mduR; ifc.mdu_data = mduD;
    ifc.pend_set  = pSet; ifc.pend_reg = pReg;
    ifc.rs_reg    = rs;   ifc.rt_reg  = rt;
    #1;
    checkVal("stall", 32'(ifc.stall), 32'(modelStall(rs, rt)));
    checkVal("mdu_ready", 32'(ifc.mdu_ready), 32'(!mBufValid));
    checkVal("hold_req", 32'(ifc.hold_req), 32'(modelHold()));

    wbWin    = wbV && (wbR != 5'd0);
    drain    = mBufValid && !wbWin;
    hs       = mduV && !mBufValid;
    expWrite = wbWin || drain;
    expReg   = wbWin ? wbR : mBufReg;
    expData  = wbWin ? wbD : mBufData;

    if (drain) mPending[mBufReg] = 1'b0;
    if (pSet && (pReg != 5'd0)) mPending[pReg] = 1'b1;
    if (mBufValid) begin
      if (drain) begin
        mBufValid = 1'b0;
        mLosses   = 0;
      end else begin
        mLosses++;
      end
    end else if (hs && (mduR != 5'd0)) begin
      mBufValid = 1'b1;
      mBufReg   = mduR;
      mBufData  = mduD;
      mLosses   = 0;
    end

    @(posedge clk);
    #1;
    checkVal("RegWrite", 32'(ifc.RegWrite), 32'(expWrite));
    if (expWrite) begin
      checkVal("WriteRegister", 32'(ifc.WriteRegister), 32'(expReg));
      checkVal("WriteData", ifc.WriteData, expData);
    end
  endtask

  task automatic idle(input bit [4:0] rs, input bit [4:0] rt);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rs, rt);
  endtask

  task automatic applyReset(input bit [4:0] rs);
    @(negedge clk);
    ifc.wb_valid = 1'b0; ifc.mdu_valid = 1'b0; ifc.pend_set = 1'b0;
    ifc.rs_reg = rs; ifc.rt_reg = rs;
    reset = 1'b0;
    #1;
    modelClear();
    checkVal("rst RegWrite", 32'(ifc.RegWrite), 32'd0);
    checkVal("rst WriteRegister", 32'(ifc.WriteRegister), 32'd0);
    checkVal("rst WriteData", ifc.WriteData, 32'd0);
    checkVal("rst hold_req", 32'(ifc.hold_req), 32'd0);
    checkVal("rst stall", 32'(ifc.stall), 32'd0);
    checkVal("rst mdu_ready", 32'(ifc.mdu_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  bit        rWbV, rMduV, rPSet;
  bit [4:0]  rWbR, rMduR, rPReg, rRs, rRt;
  bit [31:0] rWbD, rMduD;

  initial begin
    reset = 1'b0;
    ifc.wb_valid = 1'b0; ifc.wb_reg = 5'd0; ifc.wb_data = 32'd0;
    ifc.mdu_valid = 1'b0; ifc.mdu_reg = 5'd0; ifc.mdu_data = 32'd0;
    ifc.pend_set = 1'b0; ifc.pend_reg = 5'd0; ifc.rs_reg = 5'd0; ifc.rt_reg = 5'd0;
    modelClear();
    applyReset(5'd0);
    idle(5'd0, 5'd0);

    // Pipeline write and dropped reg-0 write
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    // MDU result through the buffer, plus a discarded reg-0 handshake
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    checkVal("mdu reg9 port", 32'(ifc.WriteRegister), 32'd9);
    idle(5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Starvation: buffer reg 7 loses ten slots, then the pipeline idles
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0777_0007, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 5'd3, 32'hA000_0000 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkVal("hold after starve", 32'(ifc.hold_req), 32'd1);
    idle(5'd0, 5'd0);
    checkVal("starved reg7 port", 32'(ifc.WriteRegister), 32'd7);
    idle(5'd0, 5'd0);

    // Scoreboard: set, drain clears, then same-cycle re-set wins
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 5'd0);
    idle(5'd12, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0, 5'd12, 5'd0);
    idle(5'd12, 5'd0);
    idle(5'd12, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hBEEF, 1'b0, 5'd0, 5'd0, 5'd12);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 5'd12);
    idle(5'd0, 5'd12);

    // Reset while FULL loses the buffered result and pending bits
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h2020, 1'b1, 5'd20, 5'd0, 5'd0);
    step(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyReset(5'd20);
    idle(5'd20, 5'd12);
    idle(5'd0, 5'd0);

    for (int n = 0; n < 600; n++) begin
      rWbV  = ($urandom_range(0, 99) < (modelHold() ? 15 : 55));
      rWbR  = 5'($urandom_range(0, 7));
      rWbD  = $urandom;
      rMduV = ($urandom_range(0, 99) < 35);
      rMduR = 5'($urandom_range(0, 7));
      rMduD = $urandom;
      rPSet = ($urandom_range(0, 99) < 30);
      rPReg = 5'($urandom_range(0, 7));
      rRs   = 5'($urandom_range(0, 7));
      rRt   = 5'($urandom_range(0, 7));
      step(rWbV, rWbR, rWbD, rMduV, rMduR, rMduD, rPSet, rPReg, rRs, rRt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
